toggle_event_detector: RTL and testbench



---
 rtl/toggle_event_detector.sv | 92 +++++++++
 tb/tb_toggle_event_detector.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/toggle_event_detector.sv
// Per-bit toggle detector: sticky rise/fall history, one-shot first-full-toggle pulse, covered-bit count.
// Optional `TOGGLE_DETECT_CLEAR_EN adds a `clear` input that re-arms all bits without touching `prev`.
module toggle_event_detector #(
   parameter int unsigned WIDTH = 34,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
`ifdef TOGGLE_DETECT_CLEAR_EN
   input  logic             clear,
`endif
   input  logic [WIDTH-1:0] sig,
   output logic [WIDTH-1:0] toggle_valid,
   output logic [CNT_W-1:0] covered_cnt,
   output logic             all_covered
);

   logic             clr;
   logic             primed;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] rise_seen;
   logic [WIDTH-1:0] fall_seen;
   logic [WIDTH-1:0] done;

   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] rise_seen_n;
   logic [WIDTH-1:0] fall_seen_n;
   logic [WIDTH-1:0] newly;
   logic [WIDTH-1:0] done_n;
   logic [CNT_W-1:0] newly_cnt;

`ifdef TOGGLE_DETECT_CLEAR_EN
   assign clr = clear;
`else
   assign clr = 1'b0;
`endif

   always_comb begin
      rise        = ~prev & sig;
      fall        = prev & ~sig;
      rise_seen_n = rise_seen | rise;
      fall_seen_n = fall_seen | fall;
      newly       = rise_seen_n & fall_seen_n & ~done;
      done_n      = done | newly;
      newly_cnt   = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         newly_cnt = newly_cnt + CNT_W'(newly[i]);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         prev         <= '0;
         primed       <= 1'b0;
         rise_seen    <= '0;
         fall_seen    <= '0;
         done         <= '0;
         toggle_valid <= '0;
         covered_cnt  <= '0;
         all_covered  <= 1'b0;
      end else if (clr) begin
         // prev is kept on purpose; the cleared primed flag discards it on the next enabled cycle
         primed       <= 1'b0;
         rise_seen    <= '0;
         fall_seen    <= '0;
         done         <= '0;
         toggle_valid <= '0;
         covered_cnt  <= '0;
         all_covered  <= 1'b0;
      end else if (!en) begin
         toggle_valid <= '0;
      end else if (!primed) begin
         prev         <= sig;
         primed       <= 1'b1;
         toggle_valid <= '0;
      end else begin
         prev         <= sig;
         rise_seen    <= rise_seen_n;
         fall_seen    <= fall_seen_n;
         done         <= done_n;
         toggle_valid <= newly;
         covered_cnt  <= covered_cnt + newly_cnt;
         all_covered  <= &done_n;
      end
   end

   a_cnt_bound: assert property (@(posedge clock) disable iff (reset)
      covered_cnt <= CNT_W'(WIDTH));

endmodule

// File: tb/tb_toggle_event_detector.sv
// Scoreboard bench for toggle_event_detector: the driver queues expected outputs per cycle,
// a monitor pops and compares one entry after every posedge.
module tb_toggle_event_detector;

   localparam int W  = 34;
   localparam int CW = $clog2(W + 1);

   typedef struct {
      int          id;
      logic [W-1:0]  tv;
      logic [CW-1:0] cnt;
      logic          all;
   } exp_t;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          en    = 1'b0;
`ifdef TOGGLE_DETECT_CLEAR_EN
   logic          clear = 1'b0;
`endif
   logic [W-1:0]  sig   = '0;
   logic [W-1:0]  toggle_valid;
   logic [CW-1:0] covered_cnt;
   logic          all_covered;

   exp_t q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   vec_id = 0;
   bit   done_stim = 1'b0;

   toggle_event_detector #(.WIDTH(W)) dut (
      .clock        (clock),
      .reset        (reset),
      .en           (en),
`ifdef TOGGLE_DETECT_CLEAR_EN
      .clear        (clear),
`endif
      .sig          (sig),
      .toggle_valid (toggle_valid),
      .covered_cnt  (covered_cnt),
      .all_covered  (all_covered)
   );

   always #5 clock = ~clock;

   // Apply one cycle of stimulus and queue the outputs expected after the following posedge.
   task automatic drv(input logic r, input logic e, input logic [W-1:0] s,
                      input logic [W-1:0] etv, input int ecnt, input logic eall);
      exp_t x;
      @(negedge clock);
      reset = r;
      en    = e;
      sig   = s;
      x.id  = vec_id;
      x.tv  = etv;
      x.cnt = CW'(ecnt);
      x.all = eall;
      q.push_back(x);
      vec_id++;
   endtask

   // Monitor
   initial begin
      exp_t x;
      forever begin
         @(posedge clock);
         #1;
         if (q.size() > 0) begin
            x = q.pop_front();
            n_cmp++;
            if (toggle_valid !== x.tv) begin
               n_fail++;
               $display("FAIL vec%0d toggle_valid got %h expected %h", x.id, toggle_valid, x.tv);
            end
            n_cmp++;
            if (covered_cnt !== x.cnt) begin
               n_fail++;
               $display("FAIL vec%0d covered_cnt got %0d expected %0d", x.id, covered_cnt, x.cnt);
            end
            n_cmp++;
            if (all_covered !== x.all) begin
               n_fail++;
               $display("FAIL vec%0d all_covered got %b expected %b", x.id, all_covered, x.all);
            end
         end
      end
   end

   // Stimulus
   initial begin
      logic [W-1:0] ones;
      logic [W-1:0] oh;
      ones = '1;

      // Prime suppression
      drv(1, 0, '0, '0, 0, 0);
      drv(0, 1, ones, '0, 0, 0);
      drv(0, 1, ones, '0, 0, 0);
      drv(0, 1, ones, '0, 0, 0);
      drv(0, 1, '0, '0, 0, 0);
      drv(0, 1, '0, '0, 0, 0);

      // Single bit rise then fall, then no repeat pulse
      drv(1, 0, '0, '0, 0, 0);
      drv(0, 1, '0, '0, 0, 0);
      drv(0, 1, 34'h1, '0, 0, 0);
      drv(0, 1, 34'h0, 34'h1, 1, 0);
      drv(0, 1, 34'h0, '0, 1, 0);
      drv(0, 1, 34'h1, '0, 1, 0);
      drv(0, 1, 34'h0, '0, 1, 0);

      // Multi-bit same cycle
      drv(1, 0, '0, '0, 0, 0);
      drv(0, 1, '0, '0, 0, 0);
      drv(0, 1, 34'h0_0000_00F0, '0, 0, 0);
      drv(0, 1, 34'h0, 34'h0_0000_00F0, 4, 0);
      drv(0, 1, 34'h0, '0, 4, 0);

      // Fall-then-rise order
      drv(1, 0, '0, '0, 0, 0);
      drv(0, 1, 34'h8, '0, 0, 0);
      drv(0, 1, 34'h0, '0, 0, 0);
      drv(0, 1, 34'h8, 34'h8, 1, 0);

      // Enable gating: change across a disabled window is one edge
      drv(1, 0, '0, '0, 0, 0);
      drv(0, 1, 34'h0, '0, 0, 0);
      drv(0, 0, 34'h1, '0, 0, 0);
      drv(0, 0, 34'h0, '0, 0, 0);
      drv(0, 0, 34'h1, '0, 0, 0);
      drv(0, 1, 34'h1, '0, 0, 0);
      drv(0, 1, 34'h0, 34'h1, 1, 0);
      drv(0, 0, 34'h0, '0, 1, 0);

      // Partial walk then mid-sequence reset
      drv(1, 0, '0, '0, 0, 0);
      drv(0, 1, '0, '0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         oh = '0;
         oh[i] = 1'b1;
         drv(0, 1, oh, '0, i, 0);
         drv(0, 1, '0, oh, i + 1, 0);
      end
      drv(1, 1, '0, '0, 0, 0);
      drv(0, 1, '0, '0, 0, 0);

      // Full coverage walk (previous vector primed with sig=0)
      for (int i = 0; i < W; i++) begin
         oh = '0;
         oh[i] = 1'b1;
         drv(0, 1, oh, '0, i, 0);
         drv(0, 1, '0, oh, i + 1, (i == W - 1));
      end
      drv(0, 1, ones, '0, W, 1);
      drv(0, 1, '0, '0, W, 1);

`ifdef TOGGLE_DETECT_CLEAR_EN
      // Clear with a simultaneous bit5 edge, re-prime, toggle bit5
      @(negedge clock);
      clear = 1'b1;
      reset = 1'b0;
      en    = 1'b1;
      sig   = 34'h20;
      begin
         exp_t x;
         x.id = vec_id; x.tv = '0; x.cnt = '0; x.all = 1'b0;
         q.push_back(x);
         vec_id++;
      end
      @(negedge clock);
      clear = 1'b0;
      q.push_back('{id: vec_id, tv: '0, cnt: '0, all: 1'b0});
      vec_id++;
      drv(0, 1, 34'h0, '0, 0, 0);
      drv(0, 1, 34'h20, 34'h20, 1, 0);
      drv(0, 1, 34'h20, '0, 1, 0);
`endif

      // Drain the scoreboard with a bounded wait
      for (int k = 0; k < 5 && q.size() > 0; k++) begin
         @(posedge clock);
         #2;
      end
      if (q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain pending %0d expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
